score_argmax: RTL and testbench

Classifier output stage that sits directly downstream of the fully-connected GEMM pass and its accumulator RAM. Once all OUTPUT_CHANNEL class scores have been written back, a single `start` pulse makes the block read them one per cycle from the accumulator RAM read port. It tracks the running signed maximum and reports the winning class index on `number`, with a one-cycle `done` pulse. This replaces the combinational compare over all scores with a sequential scan that needs only one RAM read port.

---
 rtl/score_argmax_if.sv | 26 ++
 rtl/score_argmax.sv | 127 ++++++++++++
 tb/tb_score_argmax.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/score_argmax_if.sv
// Control and accumulator-RAM read bus for the argmax scanner.
// slave = scanner side, master = controller/RAM side.
interface score_argmax_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int IDX_WIDTH  = 4
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [IDX_WIDTH-1:0]  number;
  logic [DATA_WIDTH-1:0] max_value;
  logic                  ram_req;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  start, ram_rdata,
    output busy, done, number, max_value, ram_req, ram_addr
  );

  modport master (
    output start, ram_rdata,
    input  busy, done, number, max_value, ram_req, ram_addr
  );
endinterface

// File: rtl/score_argmax.sv
// Sequential argmax over OUTPUT_CHANNEL signed class scores, one RAM read per cycle.
// Reports the winning index and score with a one-cycle done pulse.
module score_argmax #(
  parameter int DATA_WIDTH     = 8,
  parameter int OUTPUT_CHANNEL = 10,
  parameter int ADDR_WIDTH     = 8,
  parameter int ADDR_STRIDE    = 8,
  parameter int IDX_WIDTH      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  score_argmax_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(OUTPUT_CHANNEL - 1);

  state_t                       state_reg, state_next;
  logic [IDX_WIDTH-1:0]         issue_cnt_reg, issue_cnt_next;
  logic                         busy_reg, busy_next;
  logic                         done_reg, done_next;
  logic                         load_result;
  logic                         ram_req;

  logic                         rd_valid_reg;
  logic [IDX_WIDTH-1:0]         rd_idx_reg;

  logic signed [DATA_WIDTH-1:0] run_max_reg, run_max_next;
  logic [IDX_WIDTH-1:0]         run_idx_reg, run_idx_next;

  logic [IDX_WIDTH-1:0]         number_reg;
  logic [DATA_WIDTH-1:0]        max_value_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      issue_cnt_reg <= issue_cnt_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    issue_cnt_next = issue_cnt_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    load_result    = 1'b0;
    ram_req        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next     = SCAN;
          issue_cnt_next = '0;
          busy_next      = 1'b1;
        end
      end
      SCAN: begin
        ram_req        = 1'b1;
        issue_cnt_next = issue_cnt_reg + 1'b1;
        if (issue_cnt_reg == LAST_IDX) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Last word is on ram_rdata now; its compare and the result load share this edge.
        state_next  = IDLE;
        busy_next   = 1'b0;
        done_next   = 1'b1;
        load_result = 1'b1;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Word 0 seeds the running max; later words win only when strictly greater,
  // so ties stay with the lowest index.
  always_comb begin
    run_max_next = run_max_reg;
    run_idx_next = run_idx_reg;
    if (rd_valid_reg && ((rd_idx_reg == '0) || ($signed(bus.ram_rdata) > run_max_reg))) begin
      run_max_next = $signed(bus.ram_rdata);
      run_idx_next = rd_idx_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_reg  <= 1'b0;
      rd_idx_reg    <= '0;
      run_max_reg   <= '0;
      run_idx_reg   <= '0;
      number_reg    <= '0;
      max_value_reg <= '0;
    end else begin
      rd_valid_reg <= ram_req;
      rd_idx_reg   <= issue_cnt_reg;
      run_max_reg  <= run_max_next;
      run_idx_reg  <= run_idx_next;
      if (load_result) begin
        number_reg    <= run_idx_next;
        max_value_reg <= run_max_next;
      end
    end
  end

  assign bus.ram_req   = ram_req;
  assign bus.ram_addr  = ram_req ? ADDR_WIDTH'(issue_cnt_reg * ADDR_STRIDE) : '0;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.number    = number_reg;
  assign bus.max_value = max_value_reg;

endmodule

// File: tb/tb_score_argmax.sv
// Directed bench for score_argmax: RAM model with one-cycle read latency,
// hand-computed argmax results, timing, back-to-back and reset-abort checks.
module tb_score_argmax;

  localparam int DW = 8;
  localparam int N  = 10;
  localparam int AW = 8;
  localparam int ST = 8;
  localparam int IW = 4;

  typedef logic [DW-1:0] score_t [N];

  logic clk = 1'b0;
  logic rst_n;

  score_argmax_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IDX_WIDTH(IW)) bus ();

  score_argmax #(
    .DATA_WIDTH(DW), .OUTPUT_CHANNEL(N), .ADDR_WIDTH(AW),
    .ADDR_STRIDE(ST), .IDX_WIDTH(IW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  score_t sc;

  // Returns 8'h7F whenever no read is pending so ignored cycles would win if sampled.
  always @(posedge clk) begin
    bus.ram_rdata <= bus.ram_req ? mem[bus.ram_addr] : 8'h7F;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_req  = 0;
  int n_done = 0;
  int ncyc   = 0;
  int addr_q[$];
  int done_cyc_q[$];

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (bus.ram_req) begin
      n_req = n_req + 1;
      addr_q.push_back(int'(bus.ram_addr));
    end
    if (bus.done) begin
      n_done = n_done + 1;
      done_cyc_q.push_back(ncyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int k = 0; k < N; k++) mem[k*ST] = sc[k];
  endtask

  task automatic do_scan(input string tag, input logic [IW-1:0] exp_num,
                         input logic [DW-1:0] exp_max, input logic [IW-1:0] hold_num);
    int  lat;
    bit  seen;
    bit  changed;
    lat = -1; seen = 0; changed = 0;
    @(negedge clk);
    n_req = 0; n_done = 0; addr_q.delete();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_busy_accept"}, 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 3) bus.start = 1'b1;
      if (j == 5) bus.start = 1'b0;
      if (bus.done) begin
        lat = j;
        seen = 1;
        break;
      end
      if (bus.number !== hold_num) changed = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd11);
    chk({tag, "_number"}, 32'(bus.number), 32'(exp_num));
    chk({tag, "_max_value"}, 32'(bus.max_value), 32'(exp_max));
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_number_held"}, 32'(changed), 32'd0);
    repeat (4) @(negedge clk);
    chk({tag, "_req_cycles"}, 32'(n_req), 32'(N));
    chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    if (addr_q.size() == N) begin
      for (int k = 0; k < N; k++) chk($sformatf("%s_addr%0d", tag, k), 32'(addr_q[k]), 32'(k*ST));
    end
    $display("scan %s: number=%0d max_value=%0h latency=%0d", tag, bus.number, bus.max_value, lat);
  endtask

  initial begin
    bool_found_init();
  end

  task automatic bool_found_init();
    bus.start = 1'b0;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ram_req", 32'(bus.ram_req), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_number", 32'(bus.number), 32'd0);
    chk("rst_max_value", 32'(bus.max_value), 32'd0);
    $display("reset state checked");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Tie between indices 2 and 6 at value 7 resolves to 2.
    sc = '{8'h03, 8'hFF, 8'h07, 8'h02, 8'h00, 8'h05, 8'h07, 8'hF8, 8'h01, 8'h04};
    load_mem();
    do_scan("basic", 4'd2, 8'h07, 4'd0);

    sc = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    load_mem();
    do_scan("all_min", 4'd0, 8'h80, 4'd2);

    sc = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F};
    load_mem();
    do_scan("last_max", 4'd9, 8'h7F, 4'd0);

    sc = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h32, 8'hFB, 8'h06, 8'h07, 8'h08, 8'h09};
    load_mem();
    do_scan("win4", 4'd4, 8'h32, 4'd9);

    sc = '{8'h0A, 8'h14, 8'h1E, 8'h28, 8'hCE, 8'h3C, 8'h46, 8'h50, 8'h64, 8'h5A};
    load_mem();
    do_scan("win8", 4'd8, 8'h64, 4'd4);

    // start held high: accepted twice, second on the edge ending the first done cycle.
    sc = '{8'h03, 8'hFF, 8'h07, 8'h02, 8'h00, 8'h05, 8'h07, 8'hF8, 8'h01, 8'h04};
    load_mem();
    @(negedge clk);
    n_req = 0; n_done = 0; done_cyc_q.delete();
    bus.start = 1'b1;
    repeat (20) @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("b2b_done_pulses", 32'(n_done), 32'd2);
    chk("b2b_req_cycles", 32'(n_req), 32'(2*N));
    if (done_cyc_q.size() == 2)
      chk("b2b_period", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'(N+2));
    chk("b2b_number", 32'(bus.number), 32'd2);
    $display("back-to-back: done pulses=%0d req cycles=%0d", n_done, n_req);

    // Reset while ram_addr=40 aborts the scan.
    @(negedge clk);
    n_done = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 0;
    for (int j = 0; j < 20; j++) begin
      if (bus.ram_req && bus.ram_addr == 8'd40) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_addr40_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_ram_req", 32'(bus.ram_req), 32'd0);
    chk("abort_number", 32'(bus.number), 32'd0);
    chk("abort_max_value", 32'(bus.max_value), 32'd0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_no_done", 32'(n_done), 32'd0);
    $display("reset abort: done pulses=%0d", n_done);
    do_scan("after_abort", 4'd2, 8'h07, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
